// File: rtl/serial_add_ctrl.sv
// Bit-serial addition controller driving an external registered 1-bit full adder, LSB first.
// Define SERIAL_ADD_OVF_EN to add the signed-overflow output ovf.
module serial_add_ctrl #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned FA_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned LW = $clog2(FA_LAT + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [LW-1:0]    lat_cnt_q, lat_cnt_d;
    logic             fa_a_q, fa_a_d, fa_b_q, fa_b_d, fa_cin_q, fa_cin_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        bit_cnt_d   = bit_cnt_q;
        lat_cnt_d   = lat_cnt_q;
        fa_a_d      = fa_a_q;
        fa_b_d      = fa_b_q;
        fa_cin_d    = fa_cin_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        ovf_d       = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid && in_ready_q) begin
                    state_d    = StRun;
                    a_sh_d     = op_a >> 1;
                    b_sh_d     = op_b >> 1;
                    bit_cnt_d  = '0;
                    lat_cnt_d  = '0;
                    fa_a_d     = op_a[0];
                    fa_b_d     = op_b[0];
                    fa_cin_d   = cin;
                    sum_d      = '0;
                    cout_d     = 1'b0;
                    ovf_d      = 1'b0;
                    in_ready_d = 1'b0;
                end
            end
            StRun: begin
                if (lat_cnt_q == LW'(FA_LAT)) begin
                    lat_cnt_d          = '0;
                    sum_d[bit_cnt_q]   = fa_sum;
                    if (bit_cnt_q != CW'(WIDTH - 1)) begin
                        fa_a_d    = a_sh_q[0];
                        fa_b_d    = b_sh_q[0];
                        fa_cin_d  = fa_cout;
                        a_sh_d    = a_sh_q >> 1;
                        b_sh_d    = b_sh_q >> 1;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end else begin
                        cout_d      = fa_cout;
                        // fa_cin_q still holds the carry into the MSB here
                        ovf_d       = fa_cin_q ^ fa_cout;
                        fa_a_d      = 1'b0;
                        fa_b_d      = 1'b0;
                        fa_cin_d    = 1'b0;
                        out_valid_d = 1'b1;
                        state_d     = StDone;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q + 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            bit_cnt_q   <= '0;
            lat_cnt_q   <= '0;
            fa_a_q      <= 1'b0;
            fa_b_q      <= 1'b0;
            fa_cin_q    <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            bit_cnt_q   <= bit_cnt_d;
            lat_cnt_q   <= lat_cnt_d;
            fa_a_q      <= fa_a_d;
            fa_b_q      <= fa_b_d;
            fa_cin_q    <= fa_cin_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign fa_a      = fa_a_q;
    assign fa_b      = fa_b_q;
    assign fa_cin    = fa_cin_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf       = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl with a behavioural 2-stage registered full-adder model.
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] op_a = 8'h00;
    logic [7:0] op_b = 8'h00;
    logic       cin = 1'b0;
    logic       fa_a, fa_b, fa_cin, fa_sum, fa_cout;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] sum;
    logic       cout;
`ifdef SERIAL_ADD_OVF_EN
    logic       ovf;
`endif

    int errors = 0;
    int checks = 0;

    serial_add_ctrl #(.WIDTH(8), .FA_LAT(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .cin       (cin),
        .fa_a      (fa_a),
        .fa_b      (fa_b),
        .fa_cin    (fa_cin),
        .fa_sum    (fa_sum),
        .fa_cout   (fa_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    // Adder stage: result stable two edges after its inputs change.
    logic [1:0] fa_now;
    logic [1:0] s_pipe, c_pipe;
    assign fa_now = {1'b0, fa_a} + {1'b0, fa_b} + {1'b0, fa_cin};
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_pipe <= 2'b00;
            c_pipe <= 2'b00;
        end else begin
            s_pipe <= {s_pipe[0], fa_now[0]};
            c_pipe <= {c_pipe[0], fa_now[1]};
        end
    end
    assign fa_sum  = s_pipe[1];
    assign fa_cout = c_pipe[1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Accept one operand pair and wait for out_valid; checks latency, fa_a bit sequence, result.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic c, input logic [7:0] es, input logic ec, input logic eo);
        int cyc;
        logic [7:0] fa_bits;
        @(negedge clk);
        in_valid = 1'b1;
        op_a = a;
        op_b = b;
        cin = c;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check({tag, " in_ready_low"}, {31'b0, in_ready}, 32'd0);
        fa_bits = 8'h00;
        fa_bits[0] = fa_a;
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc % 3 == 0 && cyc < 24) fa_bits[cyc / 3] = fa_a;
        end
        check({tag, " latency"}, cyc, 32'd24);
        check({tag, " fa_a_seq"}, {24'b0, fa_bits}, {24'b0, a});
        check({tag, " sum"}, {24'b0, sum}, {24'b0, es});
        check({tag, " cout"}, {31'b0, cout}, {31'b0, ec});
`ifdef SERIAL_ADD_OVF_EN
        check({tag, " ovf"}, {31'b0, ovf}, {31'b0, eo});
`endif
    endtask

    task automatic complete(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, " out_valid_drop"}, {31'b0, out_valid}, 32'd0);
        check({tag, " in_ready_back"}, {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        check("rst in_ready", {31'b0, in_ready}, 32'd1);
        check("rst out_valid", {31'b0, out_valid}, 32'd0);
        check("rst fa_a", {31'b0, fa_a}, 32'd0);
        check("rst sum", {24'b0, sum}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst idle", {31'b0, in_ready}, 32'd1);

        run_op("0F+01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
        complete("0F+01");
        run_op("FF+00+1", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
        complete("FF+00+1");
        run_op("7F+01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        complete("7F+01");
        run_op("80+80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        complete("80+80");

        // Backpressure with in_valid pulses that must be ignored.
        run_op("3C+5A", 8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = (k % 2 == 0);
            op_a = 8'h11;
            op_b = 8'h22;
            @(posedge clk);
            #1;
            check("bp sum", {24'b0, sum}, 32'h96);
            check("bp out_valid", {31'b0, out_valid}, 32'd1);
            check("bp in_ready", {31'b0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        complete("3C+5A");
        run_op("21+43", 8'h21, 8'h43, 1'b1, 8'h65, 1'b0, 1'b0);
        complete("21+43");

        // Reset while bit 3 is being processed.
        @(negedge clk);
        in_valid = 1'b1;
        op_a = 8'hF0;
        op_b = 8'h0F;
        cin = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort fa_a", {31'b0, fa_a}, 32'd0);
        check("abort fa_b", {31'b0, fa_b}, 32'd0);
        check("abort fa_cin", {31'b0, fa_cin}, 32'd0);
        check("abort in_ready", {31'b0, in_ready}, 32'd1);
        check("abort out_valid", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("AA+55+1", 8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0);
        complete("AA+55+1");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
